// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator: en-gated H/V counters with registered blank/sync decode
// Blank and sync are decoded from the next-count values, so they land in the same register stage as the counts.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    // One extra bit so a window ending exactly at 2048/1024 still compares correctly.
    localparam logic [11:0] H_BLANK_AT = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_ON  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_BLANK_AT = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_ON  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_next;
    logic [9:0]  v_next;
    logic [11:0] h_ext;
    logic [10:0] v_ext;
    logic        hblnk_next;
    logic        vblnk_next;
    logic        hsync_win;
    logic        vsync_win;

    always_comb begin
        h_wrap = (hcount_out == H_LAST);
        v_wrap = (vcount_out == V_LAST);
        h_next = h_wrap ? 11'd0 : hcount_out + 11'd1;
        v_next = vcount_out;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : vcount_out + 10'd1;
        end
        h_ext      = {1'b0, h_next};
        v_ext      = {1'b0, v_next};
        hblnk_next = (h_ext >= H_BLANK_AT);
        vblnk_next = (v_ext >= V_BLANK_AT);
        hsync_win  = (h_ext >= H_SYNC_ON) && (h_ext < H_SYNC_OFF);
        vsync_win  = (v_ext >= V_SYNC_ON) && (v_ext < V_SYNC_OFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out  <= 11'd0;
            vcount_out  <= 10'd0;
            hblnk_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            hsync_out   <= ~H_POL;
            vsync_out   <= ~V_POL;
            frame_start <= 1'b0;
        end else begin
            // Pulse only on the enabled edge that wraps both counters; any other cycle clears it.
            frame_start <= en && h_wrap && v_wrap;
            if (en) begin
                hcount_out <= h_next;
                vcount_out <= v_next;
                hblnk_out  <= hblnk_next;
                vblnk_out  <= vblnk_next;
                hsync_out  <= hsync_win ? H_POL : ~H_POL;
                vsync_out  <= vsync_win ? V_POL : ~V_POL;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: default 800x600 timing plus two reduced-size builds (both polarities)
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    logic [10:0] b_h, s_h, n_h;
    logic [9:0]  b_v, s_v, n_v;
    logic b_hb, b_vb, b_hs, b_vs, b_fs;
    logic s_hb, s_vb, s_hs, s_vs, s_fs;
    logic n_hb, n_vb, n_hs, n_vs, n_fs;

    vga_timing_gen u_big (
        .clk(clk), .rst(rst), .en(en),
        .hcount_out(b_h), .vcount_out(b_v), .hblnk_out(b_hb), .vblnk_out(b_vb),
        .hsync_out(b_hs), .vsync_out(b_vs), .frame_start(b_fs)
    );

    // Small raster: H 8/2/3/3 = 16, V 6/1/2/2 = 11, so one frame is 176 enabled cycles.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_small (
        .clk(clk), .rst(rst), .en(en),
        .hcount_out(s_h), .vcount_out(s_v), .hblnk_out(s_hb), .vblnk_out(s_vb),
        .hsync_out(s_hs), .vsync_out(s_vs), .frame_start(s_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b0)
    ) u_neg (
        .clk(clk), .rst(rst), .en(en),
        .hcount_out(n_h), .vcount_out(n_v), .hblnk_out(n_hb), .vblnk_out(n_vb),
        .hsync_out(n_hs), .vsync_out(n_vs), .frame_start(n_fs)
    );

    logic [25:0] act_big, act_small, act_neg;
    assign act_big   = {b_h, b_v, b_hb, b_vb, b_hs, b_vs, b_fs};
    assign act_small = {s_h, s_v, s_hb, s_vb, s_hs, s_vs, s_fs};
    assign act_neg   = {n_h, n_v, n_hb, n_vb, n_hs, n_vs, n_fs};

    int   checks = 0;
    int   errors = 0;
    int   n      = 0;
    logic fs_big   = 1'b0;
    logic fs_small = 1'b0;

    function automatic logic [25:0] exp_big(input int cnt, input logic fs);
        int   h = cnt % 1056;
        int   v = (cnt / 1056) % 628;
        logic hs = (h >= 840) && (h < 968);
        logic vs = (v >= 601) && (v < 605);
        return {11'(h), 10'(v), logic'(h >= 800), logic'(v >= 600), hs, vs, fs};
    endfunction

    function automatic logic [25:0] exp_small(input int cnt, input logic pol, input logic fs);
        int   h = cnt % 16;
        int   v = (cnt / 16) % 11;
        logic hs = ((h >= 10) && (h < 13)) ? pol : ~pol;
        logic vs = ((v >= 7) && (v < 9)) ? pol : ~pol;
        return {11'(h), 10'(v), logic'(h >= 8), logic'(v >= 6), hs, vs, fs};
    endfunction

    // Drive inputs at a falling edge, let one rising edge pass, and advance the reference position.
    task automatic tick(input logic en_v, input logic rst_v);
        en  = en_v;
        rst = rst_v;
        @(negedge clk);
        fs_big   = 1'b0;
        fs_small = 1'b0;
        if (rst_v) begin
            n = 0;
        end else if (en_v) begin
            n++;
            fs_big   = (n % 663168 == 0);
            fs_small = (n % 176 == 0);
        end
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        checks++;
        if (act_big !== 26'h0) begin
            errors++;
            $display("FAIL reset_big got=%h exp=%h", act_big, 26'h0);
        end
        checks++;
        if (act_small !== 26'h0) begin
            errors++;
            $display("FAIL reset_small got=%h exp=%h", act_small, 26'h0);
        end
        checks++;
        if (act_neg !== 26'h6) begin
            errors++;
            $display("FAIL reset_neg got=%h exp=%h", act_neg, 26'h6);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (act_big !== {11'd1, 10'd0, 5'b00000}) begin
            errors++;
            $display("FAIL first_count got=%h exp=%h", act_big, {11'd1, 10'd0, 5'b00000});
        end
    endtask

    task automatic test_line0;
        while (n < 1060) begin
            tick(1'b1, 1'b0);
            checks++;
            if (act_big !== exp_big(n, fs_big)) begin
                errors++;
                $display("FAIL line0 n=%0d got=%h exp=%h", n, act_big, exp_big(n, fs_big));
            end
        end
        checks++;
        if (b_h !== 11'd4 || b_v !== 10'd1) begin
            errors++;
            $display("FAIL line0_end got=(%0d,%0d) exp=(4,1)", b_h, b_v);
        end
    endtask

    task automatic test_full_frame;
        int start_n = n;
        int pulses = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1'b1, 1'b0);
            pulses += int'(s_fs);
            checks++;
            if (act_small !== exp_small(n, 1'b1, fs_small)) begin
                errors++;
                $display("FAIL frame_small n=%0d got=%h exp=%h", n, act_small, exp_small(n, 1'b1, fs_small));
            end
            checks++;
            if (act_neg !== exp_small(n, 1'b0, fs_small)) begin
                errors++;
                $display("FAIL frame_neg n=%0d got=%h exp=%h", n, act_neg, exp_small(n, 1'b0, fs_small));
            end
            checks++;
            if (act_big !== exp_big(n, fs_big)) begin
                errors++;
                $display("FAIL frame_big n=%0d got=%h exp=%h", n, act_big, exp_big(n, fs_big));
            end
        end
        checks++;
        if (pulses != (n / 176) - (start_n / 176)) begin
            errors++;
            $display("FAIL frame_pulses got=%0d exp=%0d", pulses, (n / 176) - (start_n / 176));
        end
    endtask

    task automatic test_en_toggle;
        int   start_n = n;
        int   pulses = 0;
        logic prev_fs = 1'b0;
        for (int i = 0; i < 720; i++) begin
            tick(logic'(i % 2 == 0), 1'b0);
            pulses += int'(s_fs);
            checks++;
            if (act_small !== exp_small(n, 1'b1, fs_small)) begin
                errors++;
                $display("FAIL toggle_small i=%0d got=%h exp=%h", i, act_small, exp_small(n, 1'b1, fs_small));
            end
            checks++;
            if (act_big !== exp_big(n, fs_big)) begin
                errors++;
                $display("FAIL toggle_big i=%0d got=%h exp=%h", i, act_big, exp_big(n, fs_big));
            end
            checks++;
            if (prev_fs && s_fs) begin
                errors++;
                $display("FAIL toggle_pulse_width i=%0d got=2clk exp=1clk", i);
            end
            prev_fs = s_fs;
        end
        checks++;
        if (pulses != (n / 176) - (start_n / 176)) begin
            errors++;
            $display("FAIL toggle_pulses got=%0d exp=%0d", pulses, (n / 176) - (start_n / 176));
        end
    endtask

    task automatic test_reset_mid;
        int targets [3] = '{53, 175, 500};
        foreach (targets[k]) begin
            int budget = 0;
            // Reset first so each target is reached from a known origin.
            tick(1'b0, 1'b1);
            while (n != targets[k] && budget < 2000) begin
                tick(1'b1, 1'b0);
                budget++;
            end
            checks++;
            if (n != targets[k]) begin
                errors++;
                $display("FAIL reset_mid_reach k=%0d got=%0d exp=%0d", k, n, targets[k]);
            end
            checks++;
            if (act_small !== exp_small(n, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL reset_mid_pre k=%0d got=%h exp=%h", k, act_small, exp_small(n, 1'b1, 1'b0));
            end
            tick(1'b1, 1'b1);
            checks++;
            if (act_big !== 26'h0 || act_small !== 26'h0 || act_neg !== 26'h6) begin
                errors++;
                $display("FAIL reset_mid k=%0d got=%h/%h/%h exp=0/0/6", k, act_big, act_small, act_neg);
            end
            tick(1'b0, 1'b0);
            checks++;
            if (act_small !== 26'h0 || act_big !== 26'h0) begin
                errors++;
                $display("FAIL reset_hold k=%0d got=%h/%h exp=0/0", k, act_small, act_big);
            end
            tick(1'b1, 1'b0);
            checks++;
            if (act_small !== {11'd1, 10'd0, 5'b00000} || act_neg !== {11'd1, 10'd0, 5'b00110}) begin
                errors++;
                $display("FAIL reset_resume k=%0d got=%h/%h exp=%h/%h", k, act_small, act_neg,
                         {11'd1, 10'd0, 5'b00000}, {11'd1, 10'd0, 5'b00110});
            end
        end
    endtask

    initial begin
        test_reset();
        test_line0();
        test_full_frame();
        test_en_toggle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
